// File: rtl/packet_pkg.sv
// Shared types and constants for the crossbar session scheduler.
// The port-index type doubles as the per-output mux select encoding.
package packet_pkg;

  localparam int unsigned ADDR_WIDTH = 4;
  localparam int unsigned NUM_PORTS  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2
  } sched_state_t;

  typedef logic [1:0] port_idx_t;

  // Places the owner index in the select slot of every output the port has claimed.
  function automatic logic [2*ADDR_WIDTH-1:0] sel_contrib(input port_idx_t idx,
                                                          input logic [ADDR_WIDTH-1:0] claim);
    logic [2*ADDR_WIDTH-1:0] res;
    res = '0;
    for (int o = 0; o < ADDR_WIDTH; o++) begin
      if (claim[o]) res[2*o +: 2] = idx;
    end
    return res;
  endfunction

endpackage

// File: rtl/xbar_port_session.sv
// Per-input-port session FSM: captures a request, waits for an all-or-nothing grant,
// then holds its outputs until the final beat. Optional wait watchdog: SCHED_WATCHDOG_EN.
module xbar_port_session
  import packet_pkg::*;
#(
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned WAIT_LIMIT = 64,
  parameter port_idx_t   PORT_IDX   = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  input  logic [ADDR_WIDTH-1:0]   req_dst,
  input  logic [LEN_WIDTH-1:0]    req_len,
  output logic                    req_ready,
  input  logic                    beat_valid,
  input  logic                    arb_grant,
  input  logic [ADDR_WIDTH-1:0]   out_busy,
  output logic [ADDR_WIDTH-1:0]   arb_dst,
  output logic [ADDR_WIDTH-1:0]   claim,
  output logic [2*ADDR_WIDTH-1:0] sel_bits,
  output logic                    xfer_active,
  output logic                    xfer_last,
  output logic                    starve
);

  if (WAIT_LIMIT < 1) begin : g_bad_wait_limit
    $error("WAIT_LIMIT must be at least 1");
  end

  sched_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;

  always_comb begin
    state_d   = state_q;
    dst_d     = dst_q;
    len_d     = len_q;
    rem_d     = rem_q;
    req_ready = 1'b0;
    arb_dst   = '0;
    xfer_last = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_ready = 1'b1;
          dst_d     = req_dst;
          len_d     = (req_len == '0) ? LEN_WIDTH'(1) : req_len;
          // An empty destination mask is consumed but never scheduled.
          if (req_dst != '0) state_d = WAIT;
        end
      end
      WAIT: begin
        if ((dst_q & out_busy) == '0) arb_dst = dst_q;
        if (arb_grant && (arb_dst != '0)) begin
          state_d = XFER;
          rem_d   = len_q;
        end
      end
      XFER: begin
        if (beat_valid) begin
          rem_d = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) begin
            xfer_last = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dst_q   <= '0;
      len_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
    end
  end

  // Locks are derived from registered state so they drop with the async reset.
  assign xfer_active = (state_q == XFER);
  assign claim       = xfer_active ? dst_q : '0;
  assign sel_bits    = sel_contrib(PORT_IDX, claim);

`ifdef SCHED_WATCHDOG_EN
  localparam int unsigned WcWidth = $clog2(WAIT_LIMIT + 1);
  localparam logic [WcWidth-1:0] WcLimit = WcWidth'(WAIT_LIMIT);

  logic [WcWidth-1:0] wait_cnt_q, wait_cnt_d;
  logic               starve_q, starve_d;

  always_comb begin
    wait_cnt_d = '0;
    if (state_q == WAIT) begin
      wait_cnt_d = (wait_cnt_q == WcLimit) ? wait_cnt_q : wait_cnt_q + WcWidth'(1);
    end
    starve_d = starve_q | (wait_cnt_q == WcLimit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      starve_q   <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      starve_q   <= starve_d;
    end
  end

  assign starve = starve_q;
`else
  assign starve = 1'b0;
`endif

endmodule

// File: rtl/xbar_session_sched.sv
// Multi-beat session scheduler for the 4-port crossbar: one session FSM per input,
// output locks and mux selects merged here. Optional watchdog: SCHED_WATCHDOG_EN.
module xbar_session_sched
  import packet_pkg::*;
#(
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned WAIT_LIMIT = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORTS-1:0]              req_valid,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_dst,
  input  logic [NUM_PORTS*LEN_WIDTH-1:0]    req_len,
  output logic [NUM_PORTS-1:0]              req_ready,
  input  logic [NUM_PORTS-1:0]              beat_valid,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0]   arb_dst,
  input  logic [NUM_PORTS-1:0]              arb_grant,
  output logic [ADDR_WIDTH-1:0]             out_busy,
  output logic [2*ADDR_WIDTH-1:0]           out_sel,
  output logic [ADDR_WIDTH-1:0]             out_en,
  output logic [NUM_PORTS-1:0]              xfer_active,
  output logic [NUM_PORTS-1:0]              xfer_last,
  output logic [NUM_PORTS-1:0]              starve
);

  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   claim;
  logic [NUM_PORTS-1:0][2*ADDR_WIDTH-1:0] sel_bits;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    xbar_port_session #(
      .LEN_WIDTH  (LEN_WIDTH),
      .WAIT_LIMIT (WAIT_LIMIT),
      .PORT_IDX   (port_idx_t'(i))
    ) u_session (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid[i]),
      .req_dst     (req_dst[ADDR_WIDTH*i +: ADDR_WIDTH]),
      .req_len     (req_len[LEN_WIDTH*i +: LEN_WIDTH]),
      .req_ready   (req_ready[i]),
      .beat_valid  (beat_valid[i]),
      .arb_grant   (arb_grant[i]),
      .out_busy    (out_busy),
      .arb_dst     (arb_dst[ADDR_WIDTH*i +: ADDR_WIDTH]),
      .claim       (claim[i]),
      .sel_bits    (sel_bits[i]),
      .xfer_active (xfer_active[i]),
      .xfer_last   (xfer_last[i]),
      .starve      (starve[i])
    );
  end

  // Grants never overlap, so a plain OR of the per-port claims is collision-free.
  always_comb begin
    out_busy = '0;
    out_sel  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      out_busy = out_busy | claim[i];
      out_sel  = out_sel | sel_bits[i];
    end
  end

  always_comb begin
    out_en = '0;
    for (int o = 0; o < ADDR_WIDTH; o++) begin
      out_en[o] = out_busy[o] && beat_valid[out_sel[2*o +: 2]] && xfer_active[out_sel[2*o +: 2]];
    end
  end

endmodule

// File: tb/tb_xbar_session_sched.sv
// Self-checking bench for xbar_session_sched: the bench plays the arbiter and the input
// queues; expected per-beat outputs are queued when driven and popped when sampled.
module tb_xbar_session_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_dst;
  logic [31:0] req_len;
  logic [3:0]  req_ready;
  logic [3:0]  beat_valid;
  logic [15:0] arb_dst;
  logic [3:0]  arb_grant;
  logic [3:0]  out_busy;
  logic [7:0]  out_sel;
  logic [3:0]  out_en;
  logic [3:0]  xfer_active;
  logic [3:0]  xfer_last;
  logic [3:0]  starve;

  typedef struct packed {
    logic [3:0] en;
    logic [3:0] last;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  xbar_session_sched #(
    .LEN_WIDTH  (8),
    .WAIT_LIMIT (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_dst     (req_dst),
    .req_len     (req_len),
    .req_ready   (req_ready),
    .beat_valid  (beat_valid),
    .arb_dst     (arb_dst),
    .arb_grant   (arb_grant),
    .out_busy    (out_busy),
    .out_sel     (out_sel),
    .out_en      (out_en),
    .xfer_active (xfer_active),
    .xfer_last   (xfer_last),
    .starve      (starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got no summary / required summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    req_dst    = '0;
    req_len    = '0;
    beat_valid = '0;
    arb_grant  = '0;
    #3;
    n_cmp++;
    if ({req_ready, arb_dst, out_busy, out_sel, out_en} !== 36'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h required 0",
               {req_ready, arb_dst, out_busy, out_sel, out_en});
    end
    n_cmp++;
    if ({xfer_active, xfer_last, starve} !== 12'h0) begin
      n_bad++;
      $display("FAIL reset_status: got %h required 0", {xfer_active, xfer_last, starve});
    end
    #10;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    beat_t got;
    tick();
    req_valid = 4'b0001;
    req_dst   = 16'h0002;
    req_len   = 32'h0000_0003;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL basic_req_ready: got %b required 0001", req_ready);
    end
    tick();
    req_valid = '0;
    arb_grant = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if (arb_dst !== 16'h0002) begin
      n_bad++;
      $display("FAIL basic_arb_dst: got %h required 0002", arb_dst);
    end
    tick();
    arb_grant  = '0;
    beat_valid = 4'b0001;
    exp_q.push_back('{en: 4'b0010, last: 4'b0000});
    exp_q.push_back('{en: 4'b0010, last: 4'b0000});
    exp_q.push_back('{en: 4'b0010, last: 4'b0001});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_cmp++;
        if (out_busy !== 4'b0010 || out_sel[3:2] !== 2'd0 || xfer_active !== 4'b0001) begin
          n_bad++;
          $display("FAIL basic_lock: got busy=%b sel1=%0d act=%b required busy=0010 sel1=0 act=0001",
                   out_busy, out_sel[3:2], xfer_active);
        end
      end
      got = exp_q.pop_front();
      n_cmp++;
      if ({out_en, xfer_last} !== {got.en, got.last}) begin
        n_bad++;
        $display("FAIL basic_beat%0d: got en=%b last=%b required en=%b last=%b",
                 k, out_en, xfer_last, got.en, got.last);
      end
      tick();
    end
    beat_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (out_busy !== 4'b0000 || xfer_active !== 4'b0000) begin
      n_bad++;
      $display("FAIL basic_release: got busy=%b act=%b required 0000/0000", out_busy, xfer_active);
    end
  endtask

  task automatic test_blocked_port();
    beat_t got;
    tick();
    req_valid = 4'b0110;
    req_dst   = 16'h0130;
    req_len   = 32'h0001_0200;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0110) begin
      n_bad++;
      $display("FAIL block_req_ready: got %b required 0110", req_ready);
    end
    tick();
    req_valid = '0;
    arb_grant = 4'b0010;
    @(negedge clk);
    n_cmp++;
    if (arb_dst !== 16'h0130) begin
      n_bad++;
      $display("FAIL block_arb_both: got %h required 0130", arb_dst);
    end
    tick();
    arb_grant  = '0;
    beat_valid = 4'b0010;
    exp_q.push_back('{en: 4'b0011, last: 4'b0000});
    exp_q.push_back('{en: 4'b0011, last: 4'b0010});
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (arb_dst !== 16'h0000 || out_busy !== 4'b0011 || out_sel[3:0] !== 4'b0101) begin
        n_bad++;
        $display("FAIL block_masked%0d: got arb=%h busy=%b sel=%b required 0000/0011/0101",
                 k, arb_dst, out_busy, out_sel[3:0]);
      end
      got = exp_q.pop_front();
      n_cmp++;
      if ({out_en, xfer_last} !== {got.en, got.last}) begin
        n_bad++;
        $display("FAIL block_beat%0d: got en=%b last=%b required en=%b last=%b",
                 k, out_en, xfer_last, got.en, got.last);
      end
      tick();
    end
    beat_valid = '0;
    arb_grant  = 4'b0100;
    @(negedge clk);
    n_cmp++;
    if (arb_dst !== 16'h0100 || out_busy !== 4'b0000) begin
      n_bad++;
      $display("FAIL block_unmask: got arb=%h busy=%b required 0100/0000", arb_dst, out_busy);
    end
    tick();
    arb_grant  = '0;
    beat_valid = 4'b0100;
    exp_q.push_back('{en: 4'b0001, last: 4'b0100});
    @(negedge clk);
    got = exp_q.pop_front();
    n_cmp++;
    if ({out_en, xfer_last, out_sel[1:0]} !== {got.en, got.last, 2'd2}) begin
      n_bad++;
      $display("FAIL block_port2_beat: got en=%b last=%b sel0=%0d required en=%b last=%b sel0=2",
               out_en, xfer_last, out_sel[1:0], got.en, got.last);
    end
    tick();
    beat_valid = '0;
  endtask

  task automatic test_len0_dst0();
    beat_t got;
    tick();
    req_valid = 4'b1000;
    req_dst   = 16'h0000;
    req_len   = 32'h0500_0000;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b1000) begin
      n_bad++;
      $display("FAIL dst0_req_ready: got %b required 1000", req_ready);
    end
    tick();
    req_dst = 16'h8000;
    req_len = 32'h0000_0000;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b1000 || arb_dst !== 16'h0000) begin
      n_bad++;
      $display("FAIL dst0_stays_idle: got ready=%b arb=%h required 1000/0000", req_ready, arb_dst);
    end
    tick();
    req_valid = '0;
    arb_grant = 4'b1000;
    @(negedge clk);
    n_cmp++;
    if (arb_dst !== 16'h8000) begin
      n_bad++;
      $display("FAIL len0_arb_dst: got %h required 8000", arb_dst);
    end
    tick();
    arb_grant  = '0;
    beat_valid = 4'b1000;
    exp_q.push_back('{en: 4'b1000, last: 4'b1000});
    @(negedge clk);
    got = exp_q.pop_front();
    n_cmp++;
    if ({out_en, xfer_last, out_sel[7:6]} !== {got.en, got.last, 2'd3}) begin
      n_bad++;
      $display("FAIL len0_beat: got en=%b last=%b sel3=%0d required en=%b last=%b sel3=3",
               out_en, xfer_last, out_sel[7:6], got.en, got.last);
    end
    tick();
    beat_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (xfer_active !== 4'b0000 || out_busy !== 4'b0000) begin
      n_bad++;
      $display("FAIL len0_done: got act=%b busy=%b required 0000/0000", xfer_active, out_busy);
    end
  endtask

  task automatic test_beat_gaps();
    beat_t       got;
    logic [2:0]  bv_pat;
    bv_pat = 3'b101;
    tick();
    req_valid = 4'b0001;
    req_dst   = 16'h0004;
    req_len   = 32'h0000_0002;
    tick();
    req_valid = '0;
    arb_grant = 4'b0001;
    tick();
    arb_grant = '0;
    exp_q.push_back('{en: 4'b0100, last: 4'b0000});
    exp_q.push_back('{en: 4'b0000, last: 4'b0000});
    exp_q.push_back('{en: 4'b0100, last: 4'b0001});
    for (int k = 0; k < 3; k++) begin
      beat_valid = {3'b000, bv_pat[k]};
      @(negedge clk);
      got = exp_q.pop_front();
      n_cmp++;
      if ({out_en, xfer_last, xfer_active} !== {got.en, got.last, 4'b0001}) begin
        n_bad++;
        $display("FAIL gap_cycle%0d: got en=%b last=%b act=%b required en=%b last=%b act=0001",
                 k, out_en, xfer_last, xfer_active, got.en, got.last);
      end
      tick();
    end
    beat_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (xfer_active !== 4'b0000 || out_busy !== 4'b0000) begin
      n_bad++;
      $display("FAIL gap_done: got act=%b busy=%b required 0000/0000", xfer_active, out_busy);
    end
  endtask

  task automatic test_reset_mid();
    beat_t got;
    tick();
    req_valid = 4'b0010;
    req_dst   = 16'h0080;
    req_len   = 32'h0000_0500;
    tick();
    req_valid = '0;
    arb_grant = 4'b0010;
    tick();
    arb_grant  = '0;
    beat_valid = 4'b0010;
    @(negedge clk);
    n_cmp++;
    if (out_en !== 4'b1000 || out_sel[7:6] !== 2'd1) begin
      n_bad++;
      $display("FAIL rstmid_beat: got en=%b sel3=%0d required 1000/1", out_en, out_sel[7:6]);
    end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_busy, out_en, out_sel, xfer_active, xfer_last} !== 24'h0) begin
      n_bad++;
      $display("FAIL rstmid_async: got %h required 0",
               {out_busy, out_en, out_sel, xfer_active, xfer_last});
    end
    @(negedge clk);
    rst_n      = 1'b1;
    beat_valid = '0;
    tick();
    req_valid = 4'b0010;
    req_dst   = 16'h0010;
    req_len   = 32'h0000_0100;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL rstmid_recapture: got %b required 0010", req_ready);
    end
    tick();
    req_valid = '0;
    arb_grant = 4'b0010;
    tick();
    arb_grant  = '0;
    beat_valid = 4'b0010;
    exp_q.push_back('{en: 4'b0001, last: 4'b0010});
    @(negedge clk);
    got = exp_q.pop_front();
    n_cmp++;
    if ({out_en, xfer_last} !== {got.en, got.last}) begin
      n_bad++;
      $display("FAIL rstmid_new_beat: got en=%b last=%b required en=%b last=%b",
               out_en, xfer_last, got.en, got.last);
    end
    tick();
    beat_valid = '0;
  endtask

  task automatic test_watchdog();
    logic [3:0] exp_starve;
`ifdef SCHED_WATCHDOG_EN
    exp_starve = 4'b1000;
`else
    exp_starve = 4'b0000;
`endif
    tick();
    req_valid = 4'b1001;
    req_dst   = 16'h4004;
    req_len   = 32'h0100_0001;
    tick();
    req_valid = '0;
    arb_grant = 4'b0001;
    tick();
    arb_grant = '0;
    repeat (6) tick();
    @(negedge clk);
    n_cmp++;
    if (arb_dst !== 16'h0000 || out_busy !== 4'b0100) begin
      n_bad++;
      $display("FAIL wd_blocked: got arb=%h busy=%b required 0000/0100", arb_dst, out_busy);
    end
    n_cmp++;
    if (starve !== exp_starve) begin
      n_bad++;
      $display("FAIL wd_starve_set: got %b required %b", starve, exp_starve);
    end
    tick();
    beat_valid = 4'b0001;
    tick();
    beat_valid = '0;
    arb_grant  = 4'b1000;
    @(negedge clk);
    n_cmp++;
    if (arb_dst !== 16'h4000) begin
      n_bad++;
      $display("FAIL wd_unblocked: got %h required 4000", arb_dst);
    end
    tick();
    arb_grant  = '0;
    beat_valid = 4'b1000;
    @(negedge clk);
    n_cmp++;
    if (out_en !== 4'b0100 || xfer_last !== 4'b1000 || starve !== exp_starve) begin
      n_bad++;
      $display("FAIL wd_after_grant: got en=%b last=%b starve=%b required 0100/1000/%b",
               out_en, xfer_last, starve, exp_starve);
    end
    tick();
    beat_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (starve !== exp_starve || out_busy !== 4'b0000) begin
      n_bad++;
      $display("FAIL wd_sticky: got starve=%b busy=%b required %b/0000",
               starve, out_busy, exp_starve);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blocked_port();
    test_len0_dst0();
    test_beat_gaps();
    test_reset_mid();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
